// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: PC source select codes and fetch sequencer state encoding.
package instr_fetch_pkg;

    localparam logic [1:0] PC_SEL_DEFAULT = 2'b00;
    localparam logic [1:0] PC_SEL_IMM     = 2'b01;
    localparam logic [1:0] PC_SEL_MEMADDR = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10,
        StHold = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads the word at pc_cnt, holds it in ir until accepted
// downstream, then issues one PC advance (sequential, relative branch or absolute jump).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_cnt,
    output logic              pc_en,
    output logic [1:0]        pc_sel,
    output logic [ADDR_W-1:0] pc_imm,
    output logic [ADDR_W-1:0] pc_mem_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_addr,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_disp,
    input  logic              jmp_taken,
    input  logic [ADDR_W-1:0] jmp_target
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_d;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_addr;
    logic              r_ir_valid;
    logic              w_hs;

    assign imem_addr = pc_cnt;
    assign ir        = r_ir;
    assign ir_addr   = r_ir_addr;
    assign ir_valid  = r_ir_valid;

    assign w_hs = (r_state == StHold) & r_ir_valid & ir_ready;

    always_comb begin
        w_state_d   = r_state;
        imem_rd     = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = PC_SEL_DEFAULT;
        pc_imm      = '0;
        pc_mem_addr = '0;
        unique case (r_state)
            StIdle: w_state_d = StReq;
            StReq: begin
                imem_rd   = 1'b1;
                w_state_d = StWait;
            end
            StWait: w_state_d = StHold;
            StHold: begin
                if (w_hs) begin
                    pc_en     = 1'b1;
                    w_state_d = StReq;
                    // Jump outranks branch when both are flagged.
                    if (jmp_taken) begin
                        pc_sel      = PC_SEL_MEMADDR;
                        pc_mem_addr = jmp_target;
                    end else if (br_taken) begin
                        pc_sel = PC_SEL_IMM;
                        pc_imm = br_disp;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_ir       <= '0;
            r_ir_addr  <= '0;
            r_ir_valid <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StReq) begin
                r_ir_addr <= pc_cnt;
            end
            if (r_state == StWait) begin
                r_ir       <= imem_rdata;
                r_ir_valid <= 1'b1;
            end else if (w_hs) begin
                r_ir_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch with a transaction-level reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_cnt;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [15:0] pc_imm;
    logic [15:0] pc_mem_addr;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic [15:0] ir_addr;
    logic        ir_valid;
    logic        ir_ready;
    logic        br_taken;
    logic [15:0] br_disp;
    logic        jmp_taken;
    logic [15:0] jmp_target;

    logic [15:0] mem [256];
    int          n_vec = 0;
    int          n_err = 0;

    instr_fetch #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_cnt     (pc_cnt),
        .pc_en      (pc_en),
        .pc_sel     (pc_sel),
        .pc_imm     (pc_imm),
        .pc_mem_addr(pc_mem_addr),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_addr    (ir_addr),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .br_taken   (br_taken),
        .br_disp    (br_disp),
        .jmp_taken  (jmp_taken),
        .jmp_target (jmp_target)
    );

    always #5 clk = ~clk;

    // Environment: program counter and synchronous memory.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc_cnt <= 16'h0000;
        else if (pc_en) begin
            case (pc_sel)
                2'b00:   pc_cnt <= pc_cnt + 16'd1;
                2'b01:   pc_cnt <= pc_cnt + pc_imm;
                2'b10:   pc_cnt <= pc_mem_addr;
                default: pc_cnt <= pc_cnt;
            endcase
        end
    end

    initial imem_rdata = 16'h0000;
    always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr[7:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Model: each fetch is a transaction; m_age counts cycles since it was issued
    // (-1 = waiting one cycle after reset). Word is offered from age 2 until accepted.
    int          m_age = -1;
    logic [15:0] m_pc = 0, m_ir = 0, m_addr = 0, m_word = 0;
    bit          done = 0;

    always @(negedge clk) begin
        if (!done) begin
            if (!rst) begin
                chk("rst_valid", {31'b0, ir_valid}, 0);
                chk("rst_rd", {31'b0, imem_rd}, 0);
                chk("rst_pc_en", {31'b0, pc_en}, 0);
                chk("rst_ir", {16'b0, ir}, 0);
                chk("rst_outs", {pc_sel, pc_imm, pc_mem_addr[13:0]}, 0);
                m_age = -1; m_pc = 0; m_ir = 0; m_addr = 0;
            end else begin
                bit          e_valid, e_hs;
                logic [1:0]  e_sel;
                logic [15:0] e_imm, e_ma;
                e_valid = (m_age >= 2);
                e_hs    = e_valid && ir_ready;
                e_sel   = !e_hs ? 2'b00 : jmp_taken ? 2'b10 : br_taken ? 2'b01 : 2'b00;
                e_imm   = (e_hs && !jmp_taken && br_taken) ? br_disp : 16'h0;
                e_ma    = (e_hs && jmp_taken) ? jmp_target : 16'h0;
                chk("imem_addr", {16'b0, imem_addr}, {16'b0, m_pc});
                chk("imem_rd", {31'b0, imem_rd}, {31'b0, m_age == 0});
                chk("ir_valid", {31'b0, ir_valid}, {31'b0, e_valid});
                chk("pc_en", {31'b0, pc_en}, {31'b0, e_hs});
                chk("pc_sel", {30'b0, pc_sel}, {30'b0, e_sel});
                chk("pc_imm", {16'b0, pc_imm}, {16'b0, e_imm});
                chk("pc_mem_addr", {16'b0, pc_mem_addr}, {16'b0, e_ma});
                chk("ir", {16'b0, ir}, {16'b0, m_ir});
                chk("ir_addr", {16'b0, ir_addr}, {16'b0, m_addr});
                if (m_age == -1) m_age = 0;
                else if (m_age == 0) begin
                    m_addr = m_pc; m_word = mem[m_pc[7:0]]; m_age = 1;
                end else if (m_age == 1) begin
                    m_ir = m_word; m_age = 2;
                end else if (e_hs) begin
                    if (e_sel == 2'b10) m_pc = e_ma;
                    else if (e_sel == 2'b01) m_pc = m_pc + e_imm;
                    else m_pc = m_pc + 16'd1;
                    m_age = 0;
                end
            end
        end
    end

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ir_valid === 1'b1) return;
        end
        n_vec++; n_err++;
        $display("FAIL wait_valid: ir_valid never rose within 20 cycles");
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hA5A5;
        rst = 0; ir_ready = 0; br_taken = 0; br_disp = 0; jmp_taken = 0; jmp_target = 0;
        repeat (3) step();
        rst = 1; ir_ready = 1;
        // Cycle 0 = IDLE after release.
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) chk("first_req_rd", {31'b0, imem_rd}, 1);
            if (c == 2) chk("first_wait_valid", {31'b0, ir_valid}, 0);
            if (c < 3) step();
        end
        chk("c3_ir", {16'b0, ir}, 32'h0000A5A5);
        chk("c3_ir_addr", {16'b0, ir_addr}, 0);
        chk("c3_valid", {31'b0, ir_valid}, 1);
        chk("c3_pc_en", {31'b0, pc_en}, 1);
        chk("c3_sel", {30'b0, pc_sel}, 0);
        step(); ir_ready = 0; br_taken = 1; br_disp = 16'h1234;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("stall_ir", {16'b0, ir}, {16'b0, mem[1]});
            chk("stall_valid", {31'b0, ir_valid}, 1);
            chk("stall_pc_en", {31'b0, pc_en}, 0);
            chk("stall_rd", {31'b0, imem_rd}, 0);
            chk("stall_sel", {30'b0, pc_sel}, 0);
            step(); @(negedge clk);
        end
        step(); ir_ready = 1; br_taken = 0;
        @(negedge clk);
        chk("release_pc_en", {31'b0, pc_en}, 1);
        chk("release_sel", {30'b0, pc_sel}, 0);
        step(); br_taken = 1; br_disp = 16'hFFFC;
        @(negedge clk);
        chk("after_release_pc_en", {31'b0, pc_en}, 0);
        chk("req_addr2", {16'b0, imem_addr}, 32'h0002);
        wait_valid();
        chk("br_sel", {30'b0, pc_sel}, 1);
        chk("br_imm", {16'b0, pc_imm}, 32'h0000FFFC);
        step(); jmp_taken = 1; jmp_target = 16'h0040;
        @(negedge clk);
        chk("br_next_addr", {16'b0, imem_addr}, 32'h0000FFFE);
        wait_valid();
        chk("jmp_sel", {30'b0, pc_sel}, 2);
        chk("jmp_ma", {16'b0, pc_mem_addr}, 32'h00000040);
        chk("jmp_imm", {16'b0, pc_imm}, 0);
        step(); br_taken = 0; jmp_taken = 0;
        @(negedge clk);
        chk("jmp_next_addr", {16'b0, imem_addr}, 32'h00000040);
        step(); #2 rst = 0; #1;
        chk("async_valid", {31'b0, ir_valid}, 0);
        chk("async_ir", {16'b0, ir}, 0);
        chk("async_pc_en", {31'b0, pc_en}, 0);
        step(); step(); rst = 1;
        repeat (3) step();
        @(negedge clk);
        chk("restart_valid", {31'b0, ir_valid}, 1);
        chk("restart_ir", {16'b0, ir}, 32'h0000A5A5);
        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst        = ($urandom_range(0, 299) != 0);
            ir_ready   = ($urandom_range(0, 3) != 0);
            br_taken   = 1'($urandom);
            br_disp    = 16'($urandom);
            jmp_taken  = ($urandom_range(0, 3) == 0);
            jmp_target = 16'($urandom);
        end
        step(); rst = 1;
        @(negedge clk);
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer: the consumer of the program counter's `cnt` and the producer of its `pc_en`/`sel`/`imm`/`mem_addr` controls. It presents the current PC to the synchronous instruction memory and captures the returned word into an instruction register. It offers the word downstream with a valid/ready handshake. On each accepted instruction it issues exactly one PC advance: sequential, PC-relative branch, or absolute jump.

## Interface
- `ADDR_W`, 16, instruction address width (matches PC `cnt`).
- `DATA_W`, 16, instruction word width.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pc_cnt`  in  ADDR_W  current program counter value.
- `pc_en`  out  1  PC advance strobe, one cycle per accepted instruction.
- `pc_sel`  out  2  PC source: 00 sequential, 01 immediate-relative, 10 absolute address.
- `pc_imm`  out  ADDR_W  signed branch displacement to PC.
- `pc_mem_addr`  out  ADDR_W  absolute jump target to PC.
- `imem_addr`  out  ADDR_W  instruction memory address (= `pc_cnt`, combinational).
- `imem_rd`  out  1  memory read strobe.
- `imem_rdata`  in  DATA_W  memory read data, valid exactly 1 cycle after `imem_rd`.
- `ir`  out  DATA_W  instruction register.
- `ir_addr`  out  ADDR_W  address the word in `ir` was fetched from.
- `ir_valid`  out  1  `ir` holds an unconsumed instruction.
- `ir_ready`  in  1  downstream accepts `ir` this cycle.
- `br_taken`  in  1  with handshake: take relative branch by `br_disp`.
- `br_disp`  in  ADDR_W  signed displacement, passed unmodified.
- `jmp_taken`  in  1  with handshake: jump to `jmp_target`.
- `jmp_target`  in  ADDR_W  absolute target, passed unmodified.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered on reset. Unconditionally goes to REQ on the next edge.
- REQ: `imem_rd`=1; `ir_addr` <= `pc_cnt`. Goes to WAIT.
- WAIT: `ir` <= `imem_rdata`; `ir_valid` <= 1. Goes to HOLD.
- HOLD: `ir_valid`=1. Handshake = `ir_valid & ir_ready`.
  - No handshake: stay in HOLD; `ir` and `ir_addr` are stable.
  - Handshake: `pc_en`=1 that cycle; `ir_valid` <= 0; next state REQ.
- `pc_sel` on handshake, in priority order: `jmp_taken` selects 10 with `pc_mem_addr`=`jmp_target`; else `br_taken` selects 01 with `pc_imm`=`br_disp`; else 00.
- `pc_en`, `pc_sel`, `pc_imm`, `pc_mem_addr` are combinational (Mealy) from state and handshake. Outside a handshake cycle they are 0/00/0/0.
- `br_disp` and `jmp_target` are forwarded unmodified. Any offset correction is the PC's responsibility.
- `br_taken`, `jmp_taken`, `br_disp` and `jmp_target` are ignored outside a handshake cycle.
- PC wrap-around (FFFF->0000) is transparent; no special handling.

## Timing
- Reset values (async, immediate): state IDLE; `ir`=0, `ir_addr`=0, `ir_valid`=0, `imem_rd`=0, `pc_en`=0, `pc_sel`=00, `pc_imm`=0, `pc_mem_addr`=0.
- First fetch after reset release: REQ at cycle 1, WAIT at cycle 2, `ir_valid` high from cycle 3.
- Throughput: one instruction per 3 cycles when `ir_ready` is held high. This holds for all three PC sources.
- The PC updates on the handshake edge, so the following REQ presents the new `pc_cnt`.
- `imem_rd` is high for exactly one cycle per fetch and never during HOLD.
- Reset asserted mid-operation: the fetch is abandoned and no `pc_en` is emitted. After release, fetching restarts at IDLE.

## Structure
- Shared CPU package holds:
  - PC select constants `PC_SEL_DEFAULT`=2'b00, `PC_SEL_IMM`=2'b01, `PC_SEL_MEMADDR`=2'b10 (also used by the PC).
  - FSM state encoding constants (2 bits).
- Single flat module; no sub-module needed. The PC is instantiated alongside at CPU top level, not inside this block.

## Test plan
- Reset release with `ir_ready`=1 and memory word[0]=16'hA5A5: `ir`=A5A5, `ir_addr`=0 and `ir_valid`=1 at cycle 3; `pc_en`=1 with `pc_sel`=00 the same cycle.
- `ir_ready`=0 for 5 cycles in HOLD: `ir`/`ir_valid` are stable; `pc_en`=0 and `imem_rd`=0 throughout. On `ir_ready`=1, exactly one `pc_en` pulse.
- Handshake with `br_taken`=1, `br_disp`=16'hFFFC: `pc_sel`=01 and `pc_imm`=FFFC for one cycle; the next REQ presents the updated `pc_cnt`.
- Handshake with `br_taken`=1 and `jmp_taken`=1, `jmp_target`=16'h0040: `pc_sel`=10 and `pc_mem_addr`=0040; `pc_imm`=0.
- `rst` pulled low during WAIT: all outputs read their reset values immediately, with no `pc_en` pulse. After release, the first fetch completes at cycle 3.
- `br_taken`=1 with `ir_ready`=0: no `pc_en` and `pc_sel`=00; the branch is not latched.
